lsu_mem_stage: RTL and testbench

//  Memory stage directly downstream of the ALU. Uses alu_out as the effective address for loads/stores
//  and passes non-memory results through. Runs a req/ready + rvalid handshake with the data cache,

---
 rtl/rv32_pkg.sv | 19 +
 rtl/lsu_align.sv | 79 +++++++
 rtl/lsu_mem_stage.sv | 146 ++++++++++++++
 tb/tb_lsu_mem_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared opcode/func3 encodings and the memory-stage FSM state type.
package rv32_pkg;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: access legality, store strobe/data placement, load extraction.
module lsu_align
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      ld_func3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] rdata,
  output logic            fault,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ldata
);

  logic [XLEN-1:0] shifted_s;

  // Misaligned or unsupported width for the access kind raises a fault.
  always_comb begin
    fault = 1'b0;
    if (is_load) begin
      case (func3)
        F3_B, F3_BU: fault = 1'b0;
        F3_H, F3_HU: fault = addr[0];
        F3_W:        fault = |addr[1:0];
        default:     fault = 1'b1;
      endcase
    end else if (is_store) begin
      case (func3)
        F3_B:    fault = 1'b0;
        F3_H:    fault = addr[0];
        F3_W:    fault = |addr[1:0];
        default: fault = 1'b1;
      endcase
    end else begin
      fault = 1'b0;
    end
  end

  // Store data is replicated across lanes; the strobe selects the live bytes.
  always_comb begin
    wstrb = 4'h0;
    wdata = rs2;
    case (func3[1:0])
      2'b00: begin
        wstrb = 4'b0001 << addr[1:0];
        wdata = {4{rs2[7:0]}};
      end
      2'b01: begin
        wstrb = 4'b0011 << addr[1:0];
        wdata = {2{rs2[15:0]}};
      end
      default: begin
        wstrb = 4'hF;
        wdata = rs2;
      end
    endcase
  end

  assign shifted_s = rdata >> {ld_off, 3'b000};

  // Load extraction uses the func3/offset captured at accept time.
  always_comb begin
    ldata = rdata;
    case (ld_func3)
      F3_B:    ldata = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
      F3_BU:   ldata = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
      F3_H:    ldata = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
      F3_HU:   ldata = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage: cache req/ready + rvalid handshake, upstream stall, and the rd writeback register.
module lsu_mem_stage
  import rv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OPC_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [OPC_W-1:0] in_opcode,
  input  logic [2:0]       in_func3,
  input  logic [XLEN-1:0]  in_alu_out,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [4:0]       in_rd,
  input  logic             in_wb_en,
  output logic             stall,
  output logic             dc_req,
  output logic             dc_we,
  output logic [XLEN-1:0]  dc_addr,
  output logic [3:0]       dc_wstrb,
  output logic [XLEN-1:0]  dc_wdata,
  input  logic             dc_ready,
  input  logic             dc_rvalid,
  input  logic [XLEN-1:0]  dc_rdata,
  output logic             out_valid,
  output logic [4:0]       out_rd,
  output logic             out_wb_en,
  output logic [XLEN-1:0]  out_data,
  output logic             out_fault
);

  lsu_state_t      state_r;
  logic [2:0]      f3_r;
  logic [1:0]      off_r;
  logic [4:0]      rd_r;
  logic            wb_en_r;

  logic            is_load_s;
  logic            is_store_s;
  logic            fault_s;
  logic [3:0]      wstrb_s;
  logic [XLEN-1:0] wdata_s;
  logic [XLEN-1:0] ldata_s;

  assign is_load_s  = (in_opcode == OP_LOAD);
  assign is_store_s = (in_opcode == OP_STORE);

  lsu_align #(.XLEN(XLEN)) u_align (
    .is_load  (is_load_s),
    .is_store (is_store_s),
    .func3    (in_func3),
    .addr     (in_alu_out),
    .rs2      (in_rs2_data),
    .ld_func3 (f3_r),
    .ld_off   (off_r),
    .rdata    (dc_rdata),
    .fault    (fault_s),
    .wstrb    (wstrb_s),
    .wdata    (wdata_s),
    .ldata    (ldata_s)
  );

  // FSM, request registers and writeback registers; out_valid is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      f3_r      <= 3'd0;
      off_r     <= 2'd0;
      rd_r      <= 5'd0;
      wb_en_r   <= 1'b0;
      stall     <= 1'b0;
      dc_req    <= 1'b0;
      dc_we     <= 1'b0;
      dc_addr   <= {XLEN{1'b0}};
      dc_wstrb  <= 4'h0;
      dc_wdata  <= {XLEN{1'b0}};
      out_valid <= 1'b0;
      out_rd    <= 5'd0;
      out_wb_en <= 1'b0;
      out_data  <= {XLEN{1'b0}};
      out_fault <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            if ((is_load_s || is_store_s) && !fault_s) begin
              state_r  <= ST_REQ;
              stall    <= 1'b1;
              dc_req   <= 1'b1;
              dc_we    <= is_store_s;
              dc_addr  <= {in_alu_out[XLEN-1:2], 2'b00};
              dc_wstrb <= is_store_s ? wstrb_s : 4'h0;
              dc_wdata <= is_store_s ? wdata_s : {XLEN{1'b0}};
              f3_r     <= in_func3;
              off_r    <= in_alu_out[1:0];
              rd_r     <= in_rd;
              wb_en_r  <= in_wb_en;
            end else begin
              // Faulting memory ops and pass-through ops both report the ALU value.
              out_valid <= 1'b1;
              out_rd    <= in_rd;
              out_data  <= in_alu_out;
              out_fault <= fault_s;
              out_wb_en <= fault_s ? 1'b0 : in_wb_en;
            end
          end
        end
        ST_REQ: begin
          if (dc_ready) begin
            dc_req <= 1'b0;
            if (dc_we) begin
              state_r   <= ST_IDLE;
              stall     <= 1'b0;
              out_valid <= 1'b1;
              out_rd    <= rd_r;
              out_wb_en <= 1'b0;
              out_data  <= {XLEN{1'b0}};
              out_fault <= 1'b0;
            end else begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dc_rvalid) begin
            state_r   <= ST_IDLE;
            stall     <= 1'b0;
            out_valid <= 1'b1;
            out_rd    <= rd_r;
            out_wb_en <= wb_en_r;
            out_data  <= ldata_s;
            out_fault <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          stall   <= 1'b0;
          dc_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized self-checking bench for lsu_mem_stage against a transaction-level reference model.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_opcode;
  logic [2:0]  in_func3;
  logic [31:0] in_alu_out;
  logic [31:0] in_rs2_data;
  logic [4:0]  in_rd;
  logic        in_wb_en;
  logic        stall;
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [3:0]  dc_wstrb;
  logic [31:0] dc_wdata;
  logic        dc_ready;
  logic        dc_rvalid;
  logic [31:0] dc_rdata;
  logic        out_valid;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic [31:0] out_data;
  logic        out_fault;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.XLEN(32), .OPC_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode), .in_func3(in_func3),
    .in_alu_out(in_alu_out), .in_rs2_data(in_rs2_data), .in_rd(in_rd), .in_wb_en(in_wb_en),
    .stall(stall), .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wstrb(dc_wstrb),
    .dc_wdata(dc_wdata), .dc_ready(dc_ready), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .out_valid(out_valid), .out_rd(out_rd), .out_wb_en(out_wb_en), .out_data(out_data),
    .out_fault(out_fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check_eq({tag, "_dc_req"}, {31'd0, dc_req}, 32'd0);
    check_eq({tag, "_dc_we"}, {31'd0, dc_we}, 32'd0);
    check_eq({tag, "_dc_addr"}, dc_addr, 32'd0);
    check_eq({tag, "_dc_wstrb"}, {28'd0, dc_wstrb}, 32'd0);
    check_eq({tag, "_dc_wdata"}, dc_wdata, 32'd0);
    check_eq({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check_eq({tag, "_out_rd"}, {27'd0, out_rd}, 32'd0);
    check_eq({tag, "_out_wb_en"}, {31'd0, out_wb_en}, 32'd0);
    check_eq({tag, "_out_data"}, out_data, 32'd0);
    check_eq({tag, "_out_fault"}, {31'd0, out_fault}, 32'd0);
  endtask

  // One instruction from acceptance to writeback, with the cache responder played inline.
  // rdy_dly: cycles dc_ready stays low in REQ; rv_dly: extra WAIT cycles before rvalid.
  task automatic run_op(input logic [4:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic wb,
                        input int rdy_dly, input int rv_dly, input logic [31:0] rdata,
                        input bit gap);
    bit          is_ld, is_st, legal;
    int          nb, off;
    logic [31:0] e_strb, e_wdata, e_ld, sgn;

    is_ld = (opc == 5'b00000);
    is_st = (opc == 5'b01000);
    nb    = 1 << f3[1:0];
    off   = int'(addr[1:0]);
    legal = is_ld ? !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) : (f3 < 3'd3);
    legal = legal && ((off % nb) == 0);

    e_strb  = ((32'd1 << nb) - 32'd1) << off;
    e_wdata = (nb == 1) ? rs2[7:0] * 32'h0101_0101 :
              (nb == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
    e_ld = rdata >> (8 * off);
    if (nb < 4) begin
      e_ld = e_ld & ((32'd1 << (8 * nb)) - 32'd1);
      sgn  = 32'd1 << (8 * nb - 1);
      if (!f3[2] && ((e_ld & sgn) != 32'd0)) e_ld = e_ld - (32'd1 << (8 * nb));
    end

    check_eq("accept_stall", {31'd0, stall}, 32'd0);
    in_valid    = 1'b1;
    in_opcode   = opc;
    in_func3    = f3;
    in_alu_out  = addr;
    in_rs2_data = rs2;
    in_rd       = rd;
    in_wb_en    = wb;
    step();
    in_valid = 1'b0;

    if (!(is_ld || is_st) || !legal) begin
      check_eq("imm_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("imm_out_data", out_data, addr);
      check_eq("imm_out_rd", {27'd0, out_rd}, {27'd0, rd});
      check_eq("imm_out_fault", {31'd0, out_fault}, {31'd0, (is_ld || is_st)});
      check_eq("imm_out_wb_en", {31'd0, out_wb_en}, {31'd0, (is_ld || is_st) ? 1'b0 : wb});
      check_eq("imm_dc_req", {31'd0, dc_req}, 32'd0);
      check_eq("imm_stall", {31'd0, stall}, 32'd0);
    end else begin
      for (int i = 0; i < rdy_dly; i++) begin
        check_eq("req_hold_dc_req", {31'd0, dc_req}, 32'd1);
        check_eq("req_hold_dc_addr", dc_addr, addr & 32'hFFFF_FFFC);
        check_eq("req_hold_stall", {31'd0, stall}, 32'd1);
        check_eq("req_hold_out_valid", {31'd0, out_valid}, 32'd0);
        step();
      end
      check_eq("req_dc_req", {31'd0, dc_req}, 32'd1);
      check_eq("req_dc_addr", dc_addr, addr & 32'hFFFF_FFFC);
      check_eq("req_dc_we", {31'd0, dc_we}, {31'd0, is_st});
      check_eq("req_dc_wstrb", {28'd0, dc_wstrb}, is_st ? e_strb : 32'd0);
      if (is_st) check_eq("req_dc_wdata", dc_wdata, e_wdata);
      check_eq("req_stall", {31'd0, stall}, 32'd1);
      dc_ready = 1'b1;
      step();
      dc_ready = 1'b0;
      if (is_st) begin
        check_eq("st_out_valid", {31'd0, out_valid}, 32'd1);
        check_eq("st_out_wb_en", {31'd0, out_wb_en}, 32'd0);
        check_eq("st_out_data", out_data, 32'd0);
        check_eq("st_out_fault", {31'd0, out_fault}, 32'd0);
        check_eq("st_stall", {31'd0, stall}, 32'd0);
      end else begin
        for (int i = 0; i < rv_dly; i++) begin
          check_eq("wait_stall", {31'd0, stall}, 32'd1);
          check_eq("wait_dc_req", {31'd0, dc_req}, 32'd0);
          check_eq("wait_out_valid", {31'd0, out_valid}, 32'd0);
          step();
        end
        check_eq("wait_stall", {31'd0, stall}, 32'd1);
        dc_rvalid = 1'b1;
        dc_rdata  = rdata;
        step();
        dc_rvalid = 1'b0;
        dc_rdata  = $urandom;
        check_eq("ld_out_valid", {31'd0, out_valid}, 32'd1);
        check_eq("ld_out_data", out_data, e_ld);
        check_eq("ld_out_rd", {27'd0, out_rd}, {27'd0, rd});
        check_eq("ld_out_wb_en", {31'd0, out_wb_en}, {31'd0, wb});
        check_eq("ld_out_fault", {31'd0, out_fault}, 32'd0);
        check_eq("ld_stall", {31'd0, stall}, 32'd0);
      end
    end

    if (gap) begin
      step();
      check_eq("pulse_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("pulse_stall", {31'd0, stall}, 32'd0);
    end
  endtask

  logic [4:0] pt_ops [4] = '{5'b01100, 5'b00100, 5'b11000, 5'b01101};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_opcode = 5'd0; in_func3 = 3'd0; in_alu_out = 32'd0;
    in_rs2_data = 32'd0; in_rd = 5'd0; in_wb_en = 1'b0; dc_ready = 1'b0; dc_rvalid = 1'b0;
    dc_rdata = 32'd0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;

    // Directed cases.
    run_op(5'b01100, 3'd0, 32'h1234_5678, 32'd0, 5'd5, 1'b1, 0, 0, 32'd0, 1'b1);
    run_op(5'b01000, 3'd0, 32'h0000_1003, 32'hAABB_CCDD, 5'd0, 1'b0, 0, 0, 32'd0, 1'b1);
    run_op(5'b00000, 3'd0, 32'h0000_2002, 32'd0, 5'd7, 1'b1, 0, 0, 32'h0080_0000, 1'b0);
    run_op(5'b00000, 3'd4, 32'h0000_2002, 32'd0, 5'd8, 1'b1, 0, 0, 32'h0080_0000, 1'b0);
    run_op(5'b00000, 3'd5, 32'h0000_2002, 32'd0, 5'd9, 1'b1, 0, 0, 32'h8001_0000, 1'b1);
    run_op(5'b00000, 3'd2, 32'h0000_3000, 32'd0, 5'd10, 1'b1, 3, 3, 32'hDEAD_BEEF, 1'b1);
    run_op(5'b00000, 3'd1, 32'h0000_4001, 32'd0, 5'd11, 1'b1, 0, 0, 32'd0, 1'b1);
    run_op(5'b00000, 3'd3, 32'h0000_4000, 32'd0, 5'd12, 1'b1, 0, 0, 32'd0, 1'b1);
    run_op(5'b01000, 3'd1, 32'h0000_5002, 32'h1234_ABCD, 5'd0, 1'b0, 1, 0, 32'd0, 1'b1);

    // Reset while a load waits for data, then a late rvalid.
    in_valid = 1'b1; in_opcode = 5'b00000; in_func3 = 3'd2; in_alu_out = 32'h0000_6000;
    in_rd = 5'd13; in_wb_en = 1'b1;
    step();
    in_valid = 1'b0;
    dc_ready = 1'b1;
    step();
    dc_ready = 1'b0;
    check_eq("rstwait_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rst_in_wait");
    dc_rvalid = 1'b1;
    dc_rdata  = 32'hCAFE_F00D;
    step();
    dc_rvalid = 1'b0;
    check_eq("late_rvalid_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("late_rvalid_stall", {31'd0, stall}, 32'd0);
    run_op(5'b01100, 3'd0, 32'h1234_5678, 32'd0, 5'd5, 1'b1, 0, 0, 32'd0, 1'b1);

    // Randomized mix, including back-to-back issue in the out_valid cycle.
    for (int n = 0; n < 200; n++) begin
      int          r;
      logic [4:0]  opc;
      logic [2:0]  f3;
      logic [31:0] addr;
      r    = $urandom_range(0, 9);
      opc  = (r < 4) ? 5'b00000 : (r < 7) ? 5'b01000 : pt_ops[$urandom_range(0, 3)];
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      run_op(opc, f3, addr, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
